data_sync_bus: RTL and testbench
================================

Name: data_sync_bus

Overview:
- Destination-domain bus synchronizer for a single-bit qualifier plus a multi-bit payload crossing from a foreign clock domain.
- Passes only the enable through a parametrised NUM_STAGES flop chain. Generates a single-cycle enable pulse and captures the quasi-static bus on that pulse.
- Sits at every multi-bit CDC boundary in the system (register-file to UART TX, RX to control) in place of per-bit synchronizers.

Parameters:
- BUS_WIDTH, 8, payload width in bits; must be >= 1.
- NUM_STAGES, 2, synchronizer flops on the enable path; must be >= 2. Values < 2 are an elaboration error.
- RST_BUS_VAL, 0, reset value of sync_bus, BUS_WIDTH bits.

Ports:
- clk  input  1  destination clock.
- rst  input  1  asynchronous, active-low reset.
- unsync_bus  input  BUS_WIDTH  payload from the source domain. Held stable by the source from before bus_enable asserts until after enable_pulse is seen.
- bus_enable  input  1  source-domain qualifier. Level: high while the payload is valid.
- sync_bus  output  BUS_WIDTH  registered payload in the clk domain.
- enable_pulse  output  1  registered one-cycle pulse, high in the same cycle sync_bus first shows the new value.
- sync_enable  output  1  last synchronizer stage; for debug or status.

Behaviour:
- Reset (rst low, asynchronous): all enable chain stages = 0, pulse-history flop = 0, enable_pulse = 0, sync_bus = RST_BUS_VAL. Deassertion is sampled on the next clk rising edge.
- Enable chain: stage[0] <= bus_enable; stage[i] <= stage[i-1] for i = 1..NUM_STAGES-1. sync_enable = stage[NUM_STAGES-1].
- History flop: hist <= stage[NUM_STAGES-1] every cycle.
- Event detect (combinational): evt = stage[NUM_STAGES-1] & ~hist, i.e. rising edge of the synchronized enable.
- Outputs, registered:
  - enable_pulse <= evt.
  - sync_bus <= evt ? unsync_bus : sync_bus.
- Latency: bus_enable high setup-met before edge E0. Then stage[0] = 1 after E0, sync_enable = 1 after edge E0+NUM_STAGES-1, and enable_pulse = 1 with new sync_bus after edge E0+NUM_STAGES. enable_pulse drops after E0+NUM_STAGES+1.
- Held enable: bus_enable held high for many cycles gives exactly one pulse. No further pulse until the enable has been seen low for at least one synchronized cycle, then high again.
- Short enable: a bus_enable high narrower than one clk period may be missed. This is a source-side protocol violation and is not detected.
- Back-to-back events: minimum spacing is 2 synchronized cycles (high, low, high). That gives pulses 2 cycles apart, and both payloads are captured.
- Bus changes while no event is pending never affect sync_bus.
- Reset mid-operation: all state clears immediately. If bus_enable is still high after reset release, one new pulse is generated NUM_STAGES+1 edges later and the current bus is recaptured.
- Only the enable path is multi-flop; the payload is sampled once, on evt.

Optional Feature:
- Macro: DATA_SYNC_TOGGLE_EN.
- Defined: bus_enable is a toggle-type qualifier. The source flips it once per new payload. evt = stage[NUM_STAGES-1] ^ hist, so each rising or falling transition yields one enable_pulse and a capture. Minimum spacing between toggles is 2 synchronized cycles.
- Undefined: level/rising-edge behaviour as specified above. No toggle logic is present.

Test Plan:
- Reset: rst low with bus_enable = 1 and unsync_bus = 8'hA5 -> sync_bus = 8'h00, enable_pulse = 0, sync_enable = 0 throughout. Release rst -> pulse on the 3rd edge after release (NUM_STAGES = 2) and sync_bus = 8'hA5.
- Latency: unsync_bus = 8'h3C, bus_enable rises before edge E0 and is held 10 cycles -> enable_pulse high only in the cycle after edge E0+2, sync_bus = 8'h3C from that edge on. Exactly one pulse in total.
- Bus isolation: after capture of 8'h3C, change unsync_bus to 8'hFF with bus_enable steady high or low -> sync_bus stays 8'h3C and no pulse.
- Back-to-back: bus_enable pattern 1,0,1 (one cycle each) carrying 8'h11 then 8'h22 -> two pulses 2 cycles apart, sync_bus = 8'h11 then 8'h22.
- Reset mid-op: assert rst one cycle before the expected pulse -> no pulse, sync_bus = RST_BUS_VAL. With NUM_STAGES = 4, pulse latency = 5 edges.
- DATA_SYNC_TOGGLE_EN defined: bus_enable toggles 0->1->0, 4 cycles apart, with payloads 8'h5A then 8'hC3 -> two pulses, and sync_bus takes each value in turn.

Source files
------------

// File: rtl/data_sync_bus.sv
// Multi-bit CDC synchronizer: only the enable crosses through a flop chain, the payload is
// captured once on the synchronized event. Optional toggle qualifier via DATA_SYNC_TOGGLE_EN.
module data_sync_bus #(
    parameter int unsigned              BUS_WIDTH   = 8,
    parameter int unsigned              NUM_STAGES  = 2,
    parameter logic [BUS_WIDTH-1:0]     RST_BUS_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse,
    output logic                 sync_enable
);

    if (NUM_STAGES < 2) begin : gen_bad_stages
        $error("data_sync_bus: NUM_STAGES must be >= 2");
    end
    if (BUS_WIDTH < 1) begin : gen_bad_width
        $error("data_sync_bus: BUS_WIDTH must be >= 1");
    end

    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  hist_q;
    logic                  pulse_q, pulse_d;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  evt;

    always_comb begin
        stage_d = {stage_q[NUM_STAGES-2:0], bus_enable};
`ifdef DATA_SYNC_TOGGLE_EN
        // Every transition of the synchronized qualifier marks a new payload.
        evt = stage_q[NUM_STAGES-1] ^ hist_q;
`else
        evt = stage_q[NUM_STAGES-1] & ~hist_q;
`endif
        pulse_d = evt;
        bus_d   = evt ? unsync_bus : bus_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
            bus_q   <= RST_BUS_VAL;
        end else begin
            stage_q <= stage_d;
            hist_q  <= stage_q[NUM_STAGES-1];
            pulse_q <= pulse_d;
            bus_q   <= bus_d;
        end
    end

    assign sync_bus     = bus_q;
    assign enable_pulse = pulse_q;
    assign sync_enable  = stage_q[NUM_STAGES-1];

endmodule

// File: tb/tb_data_sync_bus.sv
// Directed bench for data_sync_bus: a 2-stage instance and a 4-stage instance with a
// non-zero reset value share stimulus.
module tb_data_sync_bus;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] unsync_bus = 8'h00;
    logic       bus_enable = 1'b0;

    logic [7:0] sync_bus2, sync_bus4;
    logic       pulse2, pulse4, se2, se4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    data_sync_bus #(.BUS_WIDTH(8), .NUM_STAGES(2), .RST_BUS_VAL(8'h00)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .unsync_bus   (unsync_bus),
        .bus_enable   (bus_enable),
        .sync_bus     (sync_bus2),
        .enable_pulse (pulse2),
        .sync_enable  (se2)
    );

    data_sync_bus #(.BUS_WIDTH(8), .NUM_STAGES(4), .RST_BUS_VAL(8'h99)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .unsync_bus   (unsync_bus),
        .bus_enable   (bus_enable),
        .sync_bus     (sync_bus4),
        .enable_pulse (pulse4),
        .sync_enable  (se4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] eb2, eb4;
        rst        = 1'b0;
        bus_enable = 1'b1;
        unsync_bus = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if ({sync_bus2, pulse2, se2} !== {8'h00, 1'b0, 1'b0})
                $display("FAIL reset_hold2: got bus=%h p=%b se=%b want bus=00 p=0 se=0",
                         sync_bus2, pulse2, se2);
            else pass_cnt++;
            total_cnt++;
            if ({sync_bus4, pulse4, se4} !== {8'h99, 1'b0, 1'b0})
                $display("FAIL reset_hold4: got bus=%h p=%b se=%b want bus=99 p=0 se=0",
                         sync_bus4, pulse4, se4);
            else pass_cnt++;
        end
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            eb2 = (i >= 3) ? 8'hA5 : 8'h00;
            eb4 = (i >= 5) ? 8'hA5 : 8'h99;
            total_cnt++;
            if ({sync_bus2, pulse2, se2} !== {eb2, (i == 3), (i >= 2)})
                $display("FAIL release2 edge %0d: got bus=%h p=%b se=%b want bus=%h p=%b se=%b",
                         i, sync_bus2, pulse2, se2, eb2, (i == 3), (i >= 2));
            else pass_cnt++;
            total_cnt++;
            if ({sync_bus4, pulse4, se4} !== {eb4, (i == 5), (i >= 4)})
                $display("FAIL release4 edge %0d: got bus=%h p=%b se=%b want bus=%h p=%b se=%b",
                         i, sync_bus4, pulse4, se4, eb4, (i == 5), (i >= 4));
            else pass_cnt++;
        end
    endtask

    task automatic settle_low();
        bus_enable = 1'b0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_latency();
        int npulse = 0;
        logic [7:0] eb;
        settle_low();
        unsync_bus = 8'h3C;
        bus_enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            npulse += int'(pulse2);
            eb = (i >= 3) ? 8'h3C : 8'hA5;
            total_cnt++;
            if ({sync_bus2, pulse2} !== {eb, (i == 3)})
                $display("FAIL latency edge %0d: got bus=%h p=%b want bus=%h p=%b",
                         i, sync_bus2, pulse2, eb, (i == 3));
            else pass_cnt++;
        end
        total_cnt++;
        if (npulse !== 1) $display("FAIL held_one_pulse: got %0d pulses want 1", npulse);
        else pass_cnt++;
    endtask

    task automatic test_bus_isolation();
        unsync_bus = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus_enable = 1'b0;
            step();
            total_cnt++;
            if ({sync_bus2, pulse2, sync_bus4, pulse4} !== {8'h3C, 1'b0, 8'h3C, 1'b0})
                $display("FAIL isolation cyc %0d: got %h/%b %h/%b want 3c/0 3c/0",
                         i, sync_bus2, pulse2, sync_bus4, pulse4);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int npulse = 0;
        logic [7:0] eb;
        settle_low();
        unsync_bus = 8'h11;
        bus_enable = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 1) bus_enable = 1'b0;
            if (i == 2) bus_enable = 1'b1;
            if (i == 3) begin
                bus_enable = 1'b0;
                unsync_bus = 8'h22;
            end
            npulse += int'(pulse2);
            eb = (i < 3) ? 8'h3C : ((i < 5) ? 8'h11 : 8'h22);
            total_cnt++;
            if ({sync_bus2, pulse2} !== {eb, (i == 3 || i == 5)})
                $display("FAIL b2b edge %0d: got bus=%h p=%b want bus=%h p=%b",
                         i, sync_bus2, pulse2, eb, (i == 3 || i == 5));
            else pass_cnt++;
        end
        total_cnt++;
        if (npulse !== 2) $display("FAIL b2b_count: got %0d pulses want 2", npulse);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        settle_low();
        unsync_bus = 8'h77;
        bus_enable = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({sync_bus2, pulse2, se2, sync_bus4, pulse4} !== {8'h00, 1'b0, 1'b0, 8'h99, 1'b0})
            $display("FAIL midop_async: got %h/%b/%b %h/%b want 00/0/0 99/0",
                     sync_bus2, pulse2, se2, sync_bus4, pulse4);
        else pass_cnt++;
        step();
        bus_enable = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total_cnt++;
            if ({sync_bus2, pulse2, sync_bus4, pulse4} !== {8'h00, 1'b0, 8'h99, 1'b0})
                $display("FAIL midop_after cyc %0d: got %h/%b %h/%b want 00/0 99/0",
                         i, sync_bus2, pulse2, sync_bus4, pulse4);
            else pass_cnt++;
        end
    endtask

`ifdef DATA_SYNC_TOGGLE_EN
    task automatic test_toggle();
        int npulse = 0;
        logic [7:0] eb;
        settle_low();
        unsync_bus = 8'h5A;
        bus_enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 4) begin
                bus_enable = 1'b0;
                unsync_bus = 8'hC3;
            end
            npulse += int'(pulse2);
            eb = (i < 3) ? 8'hA5 : ((i < 7) ? 8'h5A : 8'hC3);
            total_cnt++;
            if ({sync_bus2, pulse2} !== {eb, (i == 3 || i == 7)})
                $display("FAIL toggle edge %0d: got bus=%h p=%b want bus=%h p=%b",
                         i, sync_bus2, pulse2, eb, (i == 3 || i == 7));
            else pass_cnt++;
        end
        total_cnt++;
        if (npulse !== 2) $display("FAIL toggle_count: got %0d pulses want 2", npulse);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
`ifdef DATA_SYNC_TOGGLE_EN
        test_toggle();
`else
        test_latency();
        test_bus_isolation();
        test_back_to_back();
        test_reset_midop();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
